// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the decode/issue slice: widths, opcode and
// funct encodings, architectural register names and the ID/EX bundle payload.
package mips_isa_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;

  // Primary opcodes (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // R-type function code for jump-register (reads rs, writes nothing)
  localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'h08;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // ID/EX payload launched by the decode stage
  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  illegal;
  } idex_bundle_t;

  // Sign-extend the 16-bit immediate field to operand width
  function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational field decoder: maps an instruction word to its
// destination register, write enable, source usage and illegal flag.
module instr_field_decode
  import mips_isa_pkg::*;
(
  input  logic [DATA_W-1:0]     instr_i,
  output logic [REG_ADDR_W-1:0] dest_c_o,
  output logic                  write_c_o,
  output logic                  uses_rs_c_o,
  output logic                  uses_rt_c_o,
  output logic                  illegal_c_o
);

  logic [OPCODE_W-1:0]   opcode;
  logic [FUNCT_W-1:0]    funct;
  logic [REG_ADDR_W-1:0] rt_idx;
  logic [REG_ADDR_W-1:0] rd_idx;
  logic                  unused_fields;

  assign opcode        = instr_i[31:26];
  assign rt_idx        = instr_i[20:16];
  assign rd_idx        = instr_i[15:11];
  assign funct         = instr_i[5:0];
  // rs index, shamt and the low immediate bits do not affect control decode
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  // Opcode table; a zero destination never produces a register write
  always_comb begin
    dest_c_o    = REG_ZERO;
    write_c_o   = 1'b0;
    uses_rs_c_o = 1'b0;
    uses_rt_c_o = 1'b0;
    illegal_c_o = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_c_o    = rd_idx;
        write_c_o   = (funct != FUNCT_JR);
        uses_rs_c_o = 1'b1;
        uses_rt_c_o = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
        dest_c_o    = rt_idx;
        write_c_o   = 1'b1;
        uses_rs_c_o = 1'b1;
      end
      OP_LUI: begin
        dest_c_o  = rt_idx;
        write_c_o = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        uses_rs_c_o = 1'b1;
        uses_rt_c_o = 1'b1;
      end
      OP_J: begin
        write_c_o = 1'b0;
      end
      OP_JAL: begin
        dest_c_o  = REG_RA;
        write_c_o = 1'b1;
      end
      default: begin
        illegal_c_o = 1'b1;
      end
    endcase
    if (dest_c_o == REG_ZERO) begin
      write_c_o = 1'b0;
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// MIPS ID stage: decodes fetched instructions, reads operands from the
// register file, stalls on scoreboard hazards and launches a registered
// ID/EX bundle. Optional writeback bypass: define DECODE_WB_BYPASS_EN.
module decode_issue_stage
  import mips_isa_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_instr,
  output logic                  in_ready,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPCODE_W-1:0]   out_opcode,
  output logic [FUNCT_W-1:0]    out_funct,
  output logic [DATA_W-1:0]     out_rs_val,
  output logic [DATA_W-1:0]     out_rt_val,
  output logic [DATA_W-1:0]     out_imm,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_reg_write,
  output logic                  out_illegal
);

  logic [REG_ADDR_W-1:0] rs_idx;
  logic [REG_ADDR_W-1:0] rt_idx;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic                  dec_write;
  logic                  dec_uses_rs;
  logic                  dec_uses_rt;
  logic                  dec_illegal;

  logic                  wb_live;
  logic                  byp_rs;
  logic                  byp_rt;
  logic                  byp_dest;
  logic [DATA_W-1:0]     rs_val;
  logic [DATA_W-1:0]     rt_val;
  logic                  hazard;
  logic                  issue;

  logic                  out_valid_q, out_valid_d;
  idex_bundle_t          bundle_q, bundle_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign rs_idx    = in_instr[25:21];
  assign rt_idx    = in_instr[20:16];
  assign rf_raddr1 = rs_idx;
  assign rf_raddr2 = rt_idx;

  instr_field_decode u_field_decode (
    .instr_i     (in_instr),
    .dest_c_o    (dec_dest),
    .write_c_o   (dec_write),
    .uses_rs_c_o (dec_uses_rs),
    .uses_rt_c_o (dec_uses_rt),
    .illegal_c_o (dec_illegal)
  );

  // A writeback to r0 is architecturally meaningless and ignored everywhere
  assign wb_live = wb_en && (wb_reg != REG_ZERO);

`ifdef DECODE_WB_BYPASS_EN
  // Same-cycle writeback satisfies a dependency directly
  assign byp_rs   = wb_live && (wb_reg == rs_idx);
  assign byp_rt   = wb_live && (wb_reg == rt_idx);
  assign byp_dest = wb_live && (wb_reg == dec_dest);
`else
  // Without bypass, a dependency waits until the register file holds the value
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp_rs         = 1'b0;
  assign byp_rt         = 1'b0;
  assign byp_dest       = 1'b0;
`endif

  // Operand select: r0 reads zero, then bypass, then register-file data
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (rs_idx == REG_ZERO) begin
      rs_val = '0;
    end else if (byp_rs) begin
      rs_val = wb_data;
    end
    if (rt_idx == REG_ZERO) begin
      rt_val = '0;
    end else if (byp_rt) begin
      rt_val = wb_data;
    end
  end

  // RAW on either used source, or WAW on the destination, blocks issue
  always_comb begin
    hazard = 1'b0;
    if (dec_uses_rs && (rs_idx != REG_ZERO) && pending_q[rs_idx] && !byp_rs) begin
      hazard = 1'b1;
    end
    if (dec_uses_rt && (rt_idx != REG_ZERO) && pending_q[rt_idx] && !byp_rt) begin
      hazard = 1'b1;
    end
    if (dec_write && pending_q[dec_dest] && !byp_dest) begin
      hazard = 1'b1;
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign issue    = in_valid && in_ready;

  // Output register: flush kills, issue loads, accepted bundle drains, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d        = 1'b1;
      bundle_d.opcode    = in_instr[31:26];
      bundle_d.funct     = in_instr[5:0];
      bundle_d.rs_val    = rs_val;
      bundle_d.rt_val    = rt_val;
      bundle_d.imm       = sign_extend_imm(in_instr[15:0]);
      bundle_d.dest      = dec_dest;
      bundle_d.reg_write = dec_write;
      bundle_d.illegal   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard: retire and flush clear first so a same-cycle issue set wins
  always_comb begin
    pending_d = pending_q;
    if (wb_live) begin
      pending_d[wb_reg] = 1'b0;
    end
    if (flush && out_valid_q && bundle_q.reg_write) begin
      pending_d[bundle_q.dest] = 1'b0;
    end
    if (issue && dec_write) begin
      pending_d[dec_dest] = 1'b1;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = bundle_q.opcode;
  assign out_funct     = bundle_q.funct;
  assign out_rs_val    = bundle_q.rs_val;
  assign out_rt_val    = bundle_q.rt_val;
  assign out_imm       = bundle_q.imm;
  assign out_dest      = bundle_q.dest;
  assign out_reg_write = bundle_q.reg_write;
  assign out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: directed scenarios plus a
// randomized run against a behavioural model of the stage.
module tb_decode_issue_stage;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode, out_funct;
  logic [31:0] out_rs_val, out_rt_val, out_imm;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_illegal;

  int checks   = 0;
  int failures = 0;

  // Environment register file (r0 holds garbage the stage must ignore)
  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      rf[0] <= 32'hDEAD_BEEF;
    end else if (wb_en && wb_reg != 5'd0) begin
      rf[wb_reg] <= wb_data;
    end
  end

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_funct(out_funct),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_valid;
  logic [5:0]  m_op, m_fn;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [4:0]  m_dest;
  bit          m_wr, m_ill;
  bit   [31:0] m_pend;

  function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] d,
                                     output bit w, output bit us, output bit ut, output bit il);
    logic [5:0] op;
    op = ins[31:26];
    d = 5'd0; w = 0; us = 0; ut = 0; il = 0;
    case (op)
      6'h00:                             begin d = ins[15:11]; w = (ins[5:0] != 6'h08); us = 1; ut = 1; end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: begin d = ins[20:16]; w = 1; us = 1; end
      6'h0F:                             begin d = ins[20:16]; w = 1; end
      6'h2B, 6'h04, 6'h05:               begin us = 1; ut = 1; end
      6'h02:                             ;
      6'h03:                             begin d = 5'd31; w = 1; end
      default:                           il = 1;
    endcase
    if (d == 5'd0) w = 0;
  endfunction

  function automatic bit wb_covers(input logic [4:0] r);
    return BYP && wb_en && wb_reg == r && r != 5'd0;
  endfunction

  function automatic bit model_ready();
    logic [4:0] d, rs, rt;
    bit w, us, ut, il, stall;
    ref_decode(in_instr, d, w, us, ut, il);
    rs = in_instr[25:21];
    rt = in_instr[20:16];
    stall = 0;
    if (us && rs != 0 && m_pend[rs] && !wb_covers(rs)) stall = 1;
    if (ut && rt != 0 && m_pend[rt] && !wb_covers(rt)) stall = 1;
    if (w && m_pend[d] && !wb_covers(d)) stall = 1;
    return (!m_valid || out_ready) && !stall && !flush;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_covers(idx)) return wb_data;
    return rf[idx];
  endfunction

  function automatic void model_step();
    logic [4:0] d;
    bit w, us, ut, il, issue;
    bit [31:0] p;
    ref_decode(in_instr, d, w, us, ut, il);
    issue = in_valid && model_ready();
    p = m_pend;
    if (wb_en && wb_reg != 0) p[wb_reg] = 0;
    if (flush && m_valid && m_wr) p[m_dest] = 0;
    if (issue && w) p[d] = 1;
    if (issue) begin
      m_op = in_instr[31:26]; m_fn = in_instr[5:0];
      m_rs = operand(in_instr[25:21]); m_rt = operand(in_instr[20:16]);
      m_imm = 32'($signed(in_instr[15:0]));
      m_dest = d; m_wr = w; m_ill = il;
    end
    if (flush) m_valid = 0;
    else if (issue) m_valid = 1;
    else if (out_ready) m_valid = 0;
    m_pend = p;
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_op = 0; m_fn = 0; m_rs = 0; m_rt = 0; m_imm = 0;
    m_dest = 0; m_wr = 0; m_ill = 0; m_pend = 0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wb_en = 0; wb_reg = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic retire_all();
    idle();
    for (int r = 1; r < 32; r++) begin
      if (m_pend[r]) begin
        wb_en = 1; wb_reg = 5'(r); wb_data = $urandom;
        tick();
      end
    end
    idle();
    tick();
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = int'($urandom_range(9, 0));
    if (k < 8) return 5'(k);
    if (k == 8) return 5'd31;
    return 5'($urandom);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [15];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h0F, 6'h2B, 6'h04, 6'h05,
            6'h02, 6'h03, 6'h3F, 6'h1C};
    op = ops[$urandom_range(14, 0)];
    case ($urandom_range(3, 0))
      0: fn = 6'h20;
      1: fn = 6'h08;
      2: fn = 6'h22;
      default: fn = 6'($urandom);
    endcase
    if (op == 6'h00) return {op, pick_reg(), pick_reg(), pick_reg(), 5'($urandom), fn};
    return {op, pick_reg(), pick_reg(), 16'($urandom)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({out_valid, out_opcode, out_funct, out_rs_val, out_rt_val, out_imm, out_dest, out_reg_write, out_illegal} !== '0) begin
      failures++; $display("FAIL reset_outputs: got valid=%0b dest=%0d imm=%h, required all zero", out_valid, out_dest, out_imm);
    end
    checks++;
    if (dut.pending_q !== 32'd0) begin
      failures++; $display("FAIL reset_scoreboard: got %h required 0", dut.pending_q);
    end
  endtask

  task automatic test_raw();
    idle();
    in_valid = 1; in_instr = 32'h2005_0007; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_addi_ready: got %b required 1", in_ready); end
    tick();
    checks++;
    if ({out_valid, out_dest, out_imm, out_reg_write} !== {1'b1, 5'd5, 32'd7, 1'b1}) begin
      failures++; $display("FAIL raw_addi_bundle: got v=%b d=%0d imm=%h w=%b required v=1 d=5 imm=7 w=1", out_valid, out_dest, out_imm, out_reg_write);
    end
    checks++;
    if (dut.pending_q[5] !== 1'b1) begin failures++; $display("FAIL raw_pending5: got %b required 1", dut.pending_q[5]); end
    in_instr = 32'h00A5_3020; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall: got %b required 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall2: got %b required 0", in_ready); end
    wb_en = 1; wb_reg = 5'd5; wb_data = 32'd7; #1;
    checks++;
    if (in_ready !== BYP) begin failures++; $display("FAIL raw_wb_cycle_ready: got %b required %b", in_ready, BYP); end
    tick();
    wb_en = 0;
`ifndef DECODE_WB_BYPASS_EN
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_after_wb_ready: got %b required 1", in_ready); end
    tick();
`endif
    in_valid = 0;
    checks++;
    if ({out_valid, out_rs_val, out_rt_val, out_dest} !== {1'b1, 32'd7, 32'd7, 5'd6}) begin
      failures++; $display("FAIL raw_add_bundle: got v=%b rs=%h rt=%h d=%0d required v=1 rs=7 rt=7 d=6", out_valid, out_rs_val, out_rt_val, out_dest);
    end
    retire_all();
  endtask

  task automatic test_hold();
    idle();
    out_ready = 0; in_valid = 1; in_instr = 32'h3427_1234; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_first_ready: got %b required 1", in_ready); end
    tick();
    in_instr = 32'h2003_0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_c%0d: got %b required 0", c, in_ready); end
      checks++;
      if ({out_valid, out_opcode, out_imm, out_dest, out_reg_write} !== {1'b1, 6'h0D, 32'h0000_1234, 5'd7, 1'b1}) begin
        failures++; $display("FAIL hold_stable_c%0d: got v=%b op=%h imm=%h d=%0d", c, out_valid, out_opcode, out_imm, out_dest);
      end
      tick();
    end
    out_ready = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if ({out_valid, out_dest, out_imm} !== {1'b1, 5'd3, 32'd1}) begin
      failures++; $display("FAIL hold_next_bundle: got v=%b d=%0d imm=%h required v=1 d=3 imm=1", out_valid, out_dest, out_imm);
    end
    retire_all();
  endtask

  task automatic test_flush();
    idle();
    out_ready = 0; in_valid = 1; in_instr = 32'h8C48_0000; #1;
    tick();
    in_valid = 0;
    checks++;
    if ({out_valid, dut.pending_q[8]} !== 2'b11) begin
      failures++; $display("FAIL flush_setup: got v=%b p8=%b required 1 1", out_valid, dut.pending_q[8]);
    end
    flush = 1; out_ready = 1; in_valid = 1; in_instr = 32'h2003_0001; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b required 0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    checks++;
    if ({out_valid, dut.pending_q[8], dut.pending_q[3]} !== 3'b000) begin
      failures++; $display("FAIL flush_kill: got v=%b p8=%b p3=%b required 0 0 0", out_valid, dut.pending_q[8], dut.pending_q[3]);
    end
    retire_all();
  endtask

  task automatic test_set_wins();
    idle();
    in_valid = 1; in_instr = 32'h3C09_ABCD; wb_en = 1; wb_reg = 5'd9; wb_data = $urandom; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL setwin_ready: got %b required 1", in_ready); end
    tick();
    idle();
    checks++;
    if ({dut.pending_q[9], out_dest, out_imm} !== {1'b1, 5'd9, 32'hFFFF_ABCD}) begin
      failures++; $display("FAIL setwin_result: got p9=%b d=%0d imm=%h required 1 9 ffffabcd", dut.pending_q[9], out_dest, out_imm);
    end
    retire_all();
  endtask

  task automatic test_illegal_jal();
    idle();
    in_valid = 1; in_instr = 32'h2004_0003; #1;
    tick();
    in_instr = {6'h3F, 26'($urandom)}; #1;
    tick();
    checks++;
    if ({out_valid, out_illegal, out_reg_write} !== 3'b110) begin
      failures++; $display("FAIL illegal_bundle: got v=%b ill=%b w=%b required 1 1 0", out_valid, out_illegal, out_reg_write);
    end
    checks++;
    if (dut.pending_q !== 32'h0000_0010) begin
      failures++; $display("FAIL illegal_scoreboard: got %h required 00000010", dut.pending_q);
    end
    in_instr = 32'h0C00_0123; #1;
    tick();
    in_valid = 0;
    checks++;
    if ({out_dest, out_reg_write, out_illegal, dut.pending_q[31]} !== {5'd31, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL jal_bundle: got d=%0d w=%b ill=%b p31=%b required 31 1 0 1", out_dest, out_reg_write, out_illegal, dut.pending_q[31]);
    end
    retire_all();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    in_valid = 1; in_instr = 32'h2005_0007; #1;
    tick();
    in_instr = 32'h00A5_3020; #1;
    tick();
    checks++;
    if (dut.pending_q !== m_pend) begin failures++; $display("FAIL rst_setup_pending: got %h required %h", dut.pending_q, m_pend); end
    in_valid = 0; #2;
    reset = 0; #1;
    model_reset();
    checks++;
    if ({out_valid, dut.pending_q} !== 33'd0) begin
      failures++; $display("FAIL rst_async: got v=%b pending=%h required 0 0", out_valid, dut.pending_q);
    end
    @(posedge clk); #1;
    reset = 1; out_ready = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [114:0] exp_b, got_b;
    int cand[$];
    bit er;
    for (int n = 0; n < cycles; n++) begin
      in_valid  = ($urandom_range(99, 0) < 75);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(99, 0) < 70);
      flush     = ($urandom_range(99, 0) < 6);
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
      wb_data = $urandom;
      if (cand.size() > 0 && $urandom_range(99, 0) < 45) begin
        wb_en = 1; wb_reg = 5'(cand[$urandom_range(cand.size() - 1, 0)]);
      end else if ($urandom_range(99, 0) < 5) begin
        wb_en = 1; wb_reg = 5'd0;
      end else begin
        wb_en = 0; wb_reg = 5'($urandom);
      end
      #1;
      er = model_ready();
      checks++;
      if (in_ready !== er) begin failures++; $display("FAIL rnd_ready n=%0d: got %b required %b instr=%h", n, in_ready, er, in_instr); end
      tick();
      checks++;
      if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d: got %b required %b", n, out_valid, m_valid); end
      exp_b = {m_op, m_fn, m_rs, m_rt, m_imm, m_dest, m_wr, m_ill};
      got_b = {out_opcode, out_funct, out_rs_val, out_rt_val, out_imm, out_dest, out_reg_write, out_illegal};
      checks++;
      if (got_b !== exp_b) begin failures++; $display("FAIL rnd_bundle n=%0d: got %h required %h", n, got_b, exp_b); end
      checks++;
      if (dut.pending_q !== m_pend) begin failures++; $display("FAIL rnd_pending n=%0d: got %h required %h", n, dut.pending_q, m_pend); end
    end
    retire_all();
  endtask

  initial begin
    reset = 0;
    idle();
    in_instr = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1;
    @(posedge clk); #1;
    test_raw();
    test_hold();
    test_flush();
    test_set_wins();
    test_illegal_jal();
    test_reset_mid_stall();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
